// File: rtl/booth_seq_ctrl.sv
// -----------------------------------------------------------------------------
// booth_seq_ctrl
//   Sequential radix-2 Booth multiplier (control + datapath) for two signed
//   WIDTH-bit operands, producing a signed 2*WIDTH-bit product {A,Q}.
//   The add/subtract step is performed by an external adder: this block
//   drives as_a/as_b/as_cin and consumes as_sum in the same cycle.
//
// Ports:
//   clk, rst        clock (rising edge), synchronous active-high reset
//   in_valid/ready  operand handshake (in_ready high only in IDLE)
//   multiplicand    signed M, sampled on accept
//   multiplier      signed Q, sampled on accept
//   out_valid/ready product handshake
//   product         signed {A,Q}, meaningful only while out_valid=1
//   as_a, as_b      adder operands (A and M during CALC, else 0)
//   as_cin          adder carry-in, 1 = subtract
//   as_sum          adder result (combinational return path)
//   op_count        (BOOTH_OP_COUNT_EN only) number of add/sub iterations
//
// Optional feature macro: BOOTH_OP_COUNT_EN
// -----------------------------------------------------------------------------
module booth_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           multiplicand,
  input  logic [WIDTH-1:0]           multiplier,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2*WIDTH-1:0]         product,
  output logic [WIDTH-1:0]           as_a,
  output logic [WIDTH-1:0]           as_b,
  output logic                       as_cin,
  input  logic [WIDTH-1:0]           as_sum
`ifdef BOOTH_OP_COUNT_EN
  ,
  output logic [$clog2(WIDTH+1)-1:0] op_count
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

  // Signed-overflow detect for the add/sub step. The adder's effective b sign
  // is M's sign flipped when subtracting (a + ~b + 1).
  function automatic logic add_ovf(input logic op, input logic a_msb,
                                   input logic m_msb, input logic cin,
                                   input logic sum_msb);
    add_ovf = op & (a_msb == (m_msb ^ cin)) & (sum_msb != a_msb);
  endfunction

  logic [1:0]         state_r;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   q_r;
  logic               q1_r;
  logic [WIDTH-1:0]   m_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               in_ready_r;
  logic               out_valid_r;
  logic [2*WIDTH-1:0] product_r;
`ifdef BOOTH_OP_COUNT_EN
  logic [CNT_W-1:0]   op_count_r;
`endif

  logic               in_calc_s;
  logic               op_s;
  logic               sub_s;
  logic [WIDTH-1:0]   a_sel_s;
  logic               ov_s;
  logic               sign_s;
  logic [WIDTH-1:0]   a_shift_s;
  logic [WIDTH-1:0]   q_shift_s;

  // Booth step decode and arithmetic-shift datapath (register-only sources
  // for the adder drive so there is no input-to-output combinational path).
  always_comb begin
    in_calc_s = (state_r == ST_CALC);
    op_s      = q_r[0] ^ q1_r;
    sub_s     = q_r[0] & ~q1_r;
    if (in_calc_s) begin
      as_a   = a_r;
      as_b   = m_r;
      as_cin = sub_s;
    end else begin
      as_a   = '0;
      as_b   = '0;
      as_cin = 1'b0;
    end
    if (op_s) begin
      a_sel_s = as_sum;
    end else begin
      a_sel_s = a_r;
    end
    ov_s      = add_ovf(op_s, a_r[WIDTH-1], m_r[WIDTH-1], as_cin, as_sum[WIDTH-1]);
    // Overflow flips the apparent sign back to the true sign of A'.
    sign_s    = a_sel_s[WIDTH-1] ^ ov_s;
    a_shift_s = {sign_s, a_sel_s[WIDTH-1:1]};
    q_shift_s = {a_sel_s[0], q_r[WIDTH-1:1]};
  end

  // State machine, Booth registers and registered handshake/product outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      a_r         <= '0;
      q_r         <= '0;
      q1_r        <= 1'b0;
      m_r         <= '0;
      cnt_r       <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      product_r   <= '0;
`ifdef BOOTH_OP_COUNT_EN
      op_count_r  <= '0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            a_r        <= '0;
            q_r        <= multiplier;
            q1_r       <= 1'b0;
            m_r        <= multiplicand;
            cnt_r      <= CNT_FULL;
            in_ready_r <= 1'b0;
            state_r    <= ST_CALC;
`ifdef BOOTH_OP_COUNT_EN
            op_count_r <= '0;
`endif
          end
        end
        ST_CALC: begin
          a_r   <= a_shift_s;
          q_r   <= q_shift_s;
          q1_r  <= q_r[0];
          cnt_r <= cnt_r - CNT_ONE;
`ifdef BOOTH_OP_COUNT_EN
          if (op_s) begin
            op_count_r <= op_count_r + CNT_ONE;
          end
`endif
          if (cnt_r == CNT_ONE) begin
            state_r     <= ST_DONE;
            out_valid_r <= 1'b1;
            product_r   <= {a_shift_s, q_shift_s};
          end
        end
        ST_DONE: begin
          // A/Q are frozen here, so product stays stable until taken.
          if (out_ready) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            product_r   <= '0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          product_r   <= '0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign product   = product_r;
`ifdef BOOTH_OP_COUNT_EN
  assign op_count  = op_count_r;
`endif

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Directed self-checking bench for booth_seq_ctrl with a behavioural adder.
module tb_booth_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  multiplicand;
  logic [7:0]  multiplier;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic [7:0]  as_a;
  logic [7:0]  as_b;
  logic        as_cin;
  logic [7:0]  as_sum;
`ifdef BOOTH_OP_COUNT_EN
  logic [3:0]  op_count;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic cin_seen;

  booth_seq_ctrl #(.WIDTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .product      (product),
    .as_a         (as_a),
    .as_b         (as_b),
    .as_cin       (as_cin),
    .as_sum       (as_sum)
`ifdef BOOTH_OP_COUNT_EN
    ,
    .op_count     (op_count)
`endif
  );

  // External 8-bit adder/subtractor: a + b when cin=0, a - b when cin=1.
  assign as_sum = as_cin ? (as_a - as_b) : (as_a + as_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [7:0] m, input logic [7:0] q);
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid     = 1'b1;
    multiplicand = m;
    multiplier   = q;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Returns at the first negedge with out_valid=1 (or after the cycle bound).
  task automatic wait_result(input string tag, input logic [15:0] exp_p);
    int lat;
    lat      = 0;
    cin_seen = 1'b0;
    @(negedge clk);
    while (!out_valid && lat < 40) begin
      if (as_cin) cin_seen = 1'b1;
      lat++;
      @(negedge clk);
    end
    check({tag, "_latency"}, 32'(lat), 32'd8);
    check({tag, "_product"}, 32'(product), 32'(exp_p));
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check({tag, "_rel_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_rel_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_rel_prod"}, 32'(product), 32'd0);
  endtask

  task automatic run_mul(input string tag, input logic [7:0] m, input logic [7:0] q,
                         input logic [15:0] exp_p);
    start_op(m, q);
    wait_result(tag, exp_p);
    release_result(tag);
  endtask

`ifdef BOOTH_OP_COUNT_EN
  task automatic run_opc(input string tag, input logic [7:0] m, input logic [7:0] q,
                         input logic [15:0] exp_p, input logic [3:0] exp_c);
    start_op(m, q);
    wait_result(tag, exp_p);
    check({tag, "_opcount"}, 32'(op_count), 32'(exp_c));
    release_result(tag);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst          = 1'b1;
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    multiplicand = 8'h00;
    multiplier   = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_product", 32'(product), 32'd0);
    check("rst_as_a", 32'(as_a), 32'd0);
    check("rst_as_b", 32'(as_b), 32'd0);
    check("rst_as_cin", 32'(as_cin), 32'd0);

    run_mul("m3x5", 8'h03, 8'h05, 16'h000F);
    run_mul("mn128xn128", 8'h80, 8'h80, 16'h4000);
    run_mul("mn128x1", 8'h80, 8'h01, 16'hFF80);
    run_mul("m7xn3", 8'h07, 8'hFD, 16'hFFEB);
    run_mul("m0xn1", 8'h00, 8'hFF, 16'h0000);

    // Multiplier 0: no Booth pair is ever 10, so no subtract is requested.
    start_op(8'hFF, 8'h00);
    wait_result("mn1x0", 16'h0000);
    check("mn1x0_no_cin", 32'(cin_seen), 32'd0);
    release_result("mn1x0");

    // Back-pressure: result held while out_ready=0, new operands refused.
    start_op(8'h06, 8'h07);
    wait_result("hold", 16'h002A);
    in_valid     = 1'b1;
    multiplicand = 8'h04;
    multiplier   = 8'h03;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_product", 32'(product), 32'h002A);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_out_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("hold_idle_ready", 32'(in_ready), 32'd1);
    check("hold_idle_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_result("hold_next", 16'h000C);
    release_result("hold_next");

    // Reset during the 4th CALC cycle.
    start_op(8'h05, 8'h06);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_product", 32'(product), 32'd0);
    check("midrst_as_cin", 32'(as_cin), 32'd0);
    run_mul("m2x2", 8'h02, 8'h02, 16'h0004);

`ifdef BOOTH_OP_COUNT_EN
    run_opc("opc55", 8'h03, 8'h55, 16'h00FF, 4'd8);
    run_opc("opc00", 8'h03, 8'h00, 16'h0000, 4'd0);
    run_opc("opcFF", 8'h03, 8'hFF, 16'hFFFD, 4'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
